// File: rtl/ddc_frame_packetizer.sv
// ddc_frame_packetizer: buffers each N_CH-beat accumulator period as one frame
// and emits whole frames as 128-bit AXI4-Stream packets toward the DMA.
// Ports: s_axis_aclk/s_axis_aresetn clock and async active-low reset;
//   s_axis_ddc_tdata/tvalid/tready 96-bit input stream (tready informational);
//   m_axis_tdata/tvalid/tready/tlast 128-bit packet output;
//   drop_count/trunc_count saturating frame statistics.
// Build option: define DDC_PKT_HEADER_EN to prepend a header beat to every
// packet (magic, sequence number, drop count, N_CH).
module ddc_frame_packetizer #(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  logic         s_axis_aclk,
    input  logic         s_axis_aresetn,
    input  logic [95:0]  s_axis_ddc_tdata,
    input  logic         s_axis_ddc_tvalid,
    output logic         s_axis_ddc_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  drop_count,
    output logic [15:0]  trunc_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [BW-1:0] LAST_CH = BW'(N_CH - 1);
    localparam logic [BW-1:0] BONE    = BW'(1);
    localparam logic [AW:0]   PONE    = (AW+1)'(1);
    localparam logic [31:0]   HDR_MAGIC = 32'hDDC0_0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef DDC_PKT_HEADER_EN
        S_HDR  = 2'd1,
`endif
        S_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Input side
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          acc_q, acc_d;
    logic [AW:0]   base_q, base_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   occ;
    logic          fits, start, last_beat, wr_en, commit;
    logic          drop_ev, trunc_ev;

    // Output side
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] dcnt_q, dcnt_d;
    logic [AW:0]   frames_q, frames_d;
    logic [31:0]   seq_q, seq_d;
    logic          data_hs, pkt_done;

    logic [31:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   trunc_cnt_q, trunc_cnt_d;
    logic          rdy_q;

`ifdef DDC_PKT_HEADER_EN
    logic [31:0]   hdr_drop_q;
`endif

    logic [127:0]  mem [FIFO_DEPTH];

    assign s_axis_ddc_tready = rdy_q;
    assign drop_count        = drop_cnt_q;
    assign trunc_count       = trunc_cnt_q;

    // Frame acceptance, write pointer and rollback
    always_comb begin
        occ       = wr_ptr_q - rd_ptr_q;
        fits      = (32'(FIFO_DEPTH) - 32'(occ)) >= 32'(N_CH);
        start     = s_axis_ddc_tvalid && (bcnt_q == '0);
        last_beat = s_axis_ddc_tvalid && (bcnt_q == LAST_CH);
        wr_en     = s_axis_ddc_tvalid && (start ? fits : acc_q);
        commit    = wr_en && last_beat;
        drop_ev   = start && !fits;
        // acc_q is stale between frames, bcnt != 0 limits this to mid-frame
        trunc_ev  = !s_axis_ddc_tvalid && (bcnt_q != '0) && acc_q;

        bcnt_d   = bcnt_q;
        acc_d    = acc_q;
        base_d   = base_q;
        wr_ptr_d = wr_ptr_q;
        if (!s_axis_ddc_tvalid) begin
            bcnt_d = '0;
            if (trunc_ev) begin
                wr_ptr_d = base_q;
            end
        end else begin
            bcnt_d = last_beat ? '0 : bcnt_q + BONE;
            if (start) begin
                acc_d  = fits;
                base_d = wr_ptr_q;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PONE;
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (drop_ev && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
        trunc_cnt_d = trunc_cnt_q;
        if (trunc_ev && (trunc_cnt_q != '1)) begin
            trunc_cnt_d = trunc_cnt_q + 16'd1;
        end
    end

    // Storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {16'(bcnt_q), 16'h0000, s_axis_ddc_tdata};
        end
    end

    // Read side bookkeeping
    always_comb begin
        data_hs  = (state_q == S_DATA) && m_axis_tready;
        pkt_done = data_hs && (dcnt_q == LAST_CH);

        rd_ptr_d = data_hs ? rd_ptr_q + PONE : rd_ptr_q;

        dcnt_d = dcnt_q;
        if (data_hs) begin
            dcnt_d = pkt_done ? '0 : dcnt_q + BONE;
        end

        frames_d = frames_q;
        if (commit && !pkt_done) begin
            frames_d = frames_q + PONE;
        end else if (!commit && pkt_done) begin
            frames_d = frames_q - PONE;
        end

        seq_d = seq_q;
`ifdef DDC_PKT_HEADER_EN
        if ((state_q == S_HDR) && m_axis_tready) begin
            seq_d = seq_q + 32'd1;
        end
`else
        if (pkt_done) begin
            seq_d = seq_q + 32'd1;
        end
`endif
    end

    // FSM: state register
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (frames_q != '0) begin
`ifdef DDC_PKT_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef DDC_PKT_HEADER_EN
            S_HDR: begin
                if (m_axis_tready) begin
                    state_d = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (pkt_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; data comes straight from storage so no read bubble
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        unique case (state_q)
`ifdef DDC_PKT_HEADER_EN
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {HDR_MAGIC, seq_q, hdr_drop_q, 32'(N_CH)};
            end
`endif
            S_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (dcnt_q == LAST_CH);
                m_axis_tdata  = mem[rd_ptr_q[AW-1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            bcnt_q      <= '0;
            acc_q       <= 1'b0;
            base_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dcnt_q      <= '0;
            frames_q    <= '0;
            seq_q       <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dcnt_q      <= dcnt_d;
            frames_q    <= frames_d;
            seq_q       <= seq_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            rdy_q       <= 1'b1;
        end
    end

`ifdef DDC_PKT_HEADER_EN
    // Latch the count the header will carry, including a drop in the
    // entry cycle, so the field stays stable while the header stalls.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            hdr_drop_q <= '0;
        end else if ((state_q == S_IDLE) && (state_d == S_HDR)) begin
            hdr_drop_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ddc_frame_packetizer.sv
// Self-checking bench for ddc_frame_packetizer: randomized frames against a
// frame-level reference model, with a scoreboard-driven output monitor.
module tb_ddc_frame_packetizer;

    localparam int N_CH  = 4;
    localparam int DEPTH = 64;

    logic         clk;
    logic         rst_n;
    logic [95:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [31:0]  drop_count;
    logic [15:0]  trunc_count;

    ddc_frame_packetizer #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH)) dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rst_n),
        .s_axis_ddc_tdata  (s_tdata),
        .s_axis_ddc_tvalid (s_tvalid),
        .s_axis_ddc_tready (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast),
        .drop_count        (drop_count),
        .trunc_count       (trunc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] d;
        bit           last;
        bit           hdr;
    } exp_t;

    exp_t exp_q[$];
    int   drop_cyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_occ = 0;
    int   m_seq = 0;
    int   m_drops = 0;
    int   m_truncs = 0;
    int   tr_mode = 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Downstream ready: 0 = held low, 1 = held high, 2 = random
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor
    bit           stall_v = 1'b0;
    logic [127:0] stall_d;
    logic         stall_l;
    int           beat_cyc = 0;
    exp_t         me;
    int           nd;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", 128'(m_tvalid), 128'(1));
                chk("stall_data", m_tdata, stall_d);
                chk("stall_last", 128'(m_tlast), 128'(stall_l));
            end
            if (m_tvalid && !stall_v) beat_cyc = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h, required none", m_tdata);
                end else begin
                    me = exp_q.pop_front();
                    if (me.hdr) begin
                        nd = 0;
                        foreach (drop_cyc_q[i]) if (drop_cyc_q[i] < beat_cyc) nd++;
                        me.d[63:32] = 32'(nd);
                    end
                    chk(me.hdr ? "hdr_beat" : "data_beat", m_tdata, me.d);
                    chk("tlast", 128'(m_tlast), 128'(me.last));
                    if (!me.hdr) m_occ--;
                end
            end
            stall_v = m_tvalid && !m_tready;
            stall_d = m_tdata;
            stall_l = m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            s_tvalid = 1'b0;
        end
    endtask

    // Drive nb beats back to back; the model decides the frame's fate from
    // the occupancy it tracks. A short frame must be followed by idle.
    task automatic send_frame(input int nb, input bit ramp);
        logic [95:0] d[$];
        logic [95:0] v;
        bit          acc = 1'b0;
        exp_t        e;
        for (int b = 0; b < nb; b++) begin
            tick();
            if (b == 0) begin
                acc = (DEPTH - m_occ) >= N_CH;
                if (!acc) begin
                    m_drops++;
                    drop_cyc_q.push_back(cyc);
                end
            end
            v = ramp ? 96'(b + 1) : {$urandom(), $urandom(), $urandom()};
            s_tvalid = 1'b1;
            s_tdata  = v;
            d.push_back(v);
        end
        if (acc && nb == N_CH) begin
`ifdef DDC_PKT_HEADER_EN
            e.d    = {32'hDDC0_0001, 32'(m_seq), 32'h0, 32'(N_CH)};
            e.last = 1'b0;
            e.hdr  = 1'b1;
            exp_q.push_back(e);
`endif
            m_seq++;
            for (int b = 0; b < N_CH; b++) begin
                e.d    = {16'(b), 16'h0000, d[b]};
                e.last = (b == N_CH - 1);
                e.hdr  = 1'b0;
                exp_q.push_back(e);
            end
            m_occ += N_CH;
        end else if (acc) begin
            m_truncs++;
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d beats outstanding, required 0",
                     nm, exp_q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int gap;
        int nb;
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_tlast", 128'(m_tlast), 128'(0));
        chk("rst_tdata", m_tdata, 128'(0));
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_drop", 128'(drop_count), 128'(0));
        chk("rst_trunc", 128'(trunc_count), 128'(0));
        repeat (3) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        chk("s_tready_up", 128'(s_tready), 128'(1));

        // Single ramp frame: first output beat lands exactly in T+2
        send_frame(N_CH, 1'b1);
        tick();
        s_tvalid = 1'b0;
        chk("t1_no_valid", 128'(m_tvalid), 128'(0));
        tick();
        chk("t2_valid", 128'(m_tvalid), 128'(1));
`ifdef DDC_PKT_HEADER_EN
        chk("t2_is_hdr", 128'(m_tdata[127:96]), 128'(32'hDDC0_0001));
`else
        chk("t2_is_ch0", 128'(m_tdata[127:112]), 128'(0));
`endif
        drain("single");

        // Truncated frame then a normal one
        send_frame(2, 1'b0);
        idle(4);
        chk("trunc_count", 128'(trunc_count), 128'(m_truncs));
        chk("trunc_no_out", 128'(exp_q.size()), 128'(0));
        send_frame(N_CH, 1'b0);
        idle(1);
        drain("after_trunc");

        // Overflow burst with the output stalled
        tr_mode = 0;
        tick();
        for (int f = 0; f < 30; f++) send_frame(N_CH, 1'b0);
        idle(2);
        chk("drop_burst", 128'(drop_count), 128'(m_drops));
        chk("drop_burst_14", 128'(drop_count), 128'(14));
        tr_mode = 1;
        drain("burst");

        // Random ready, gaps and occasional truncation
        tr_mode = 2;
        for (int f = 0; f < 100; f++) begin
            nb  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, N_CH - 1) : N_CH;
            gap = (nb < N_CH) ? $urandom_range(1, 3) : $urandom_range(0, 2);
            send_frame(nb, 1'b0);
            if (gap > 0) idle(gap);
        end
        idle(1);
        drain("random");
        chk("rand_drop", 128'(drop_count), 128'(m_drops));
        chk("rand_trunc", 128'(trunc_count), 128'(m_truncs));

        // Reset while a data beat is being presented
        send_frame(N_CH, 1'b0);
        idle(1);
        n = 0;
        while (!(m_tvalid && m_tdata[127:112] < 16'(N_CH)) && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_bad++;
            $display("FAIL midpkt_timeout: got no data beat, required one");
        end
        #2 rst_n = 1'b0;
        exp_q.delete();
        drop_cyc_q.delete();
        m_occ    = 0;
        m_seq    = 0;
        m_drops  = 0;
        m_truncs = 0;
        #1;
        chk("arst_tvalid", 128'(m_tvalid), 128'(0));
        chk("arst_tdata", m_tdata, 128'(0));
        chk("arst_tlast", 128'(m_tlast), 128'(0));
        chk("arst_drop", 128'(drop_count), 128'(0));
        chk("arst_trunc", 128'(trunc_count), 128'(0));
        tr_mode = 1;
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        send_frame(N_CH, 1'b0);
        idle(1);
        drain("post_reset");
        chk("post_drop", 128'(drop_count), 128'(0));
        chk("post_trunc", 128'(trunc_count), 128'(0));

        idle(5);
        chk("leftover", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
